wb_ram_slave: RTL and testbench
===============================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two, 2..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wb_bus  interface  wb_bus_t.slave  Wishbone slave end; it uses wb_cyc, wb_stb, wb_we, wb_adr[31:0], wb_sel[3:0] and wb_dat_ms[31:0] in, and drives wb_dat_sm[31:0], wb_ack and wb_err out.

Function
REQ-006 SHALL implement FSM states IDLE and RESP.
REQ-007 In IDLE, with wb_cyc & wb_stb high at a clock edge, SHALL capture the access and go to RESP.
- Otherwise it SHALL stay in IDLE.
REQ-008 A write (wb_we=1) SHALL commit at the capture edge.
- Byte lane n is written only when wb_sel[n]=1.
- wb_sel=4'b0000 leaves memory unchanged but is still acknowledged.
REQ-009 A read (wb_we=0) SHALL register the addressed word into wb_dat_sm at the capture edge.
- wb_dat_sm holds that value until the next read capture.
REQ-010 In RESP, wb_ack SHALL be 1 only while wb_cyc & wb_stb are high.
- This gives exactly one ack per access, one cycle after capture (latency 1).
REQ-011 RESP SHALL return to IDLE unconditionally after one cycle.
REQ-012 If wb_stb is still high in that IDLE cycle, it SHALL be captured as a new access.
- Back-to-back accesses therefore complete every 2 cycles, and a held strobe is never double-acked within one RESP.
REQ-013 Abort: if wb_cyc or wb_stb falls while in RESP, no ack SHALL be issued.
- A write already committed stays committed.
REQ-014 Word index SHALL be (wb_adr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- wb_adr[1:0] is ignored.
REQ-015 wb_ack and wb_err SHALL never be high in the same cycle.
REQ-016 wb_dat_sm SHALL be ignored by the master on writes; its value on writes is unspecified-stable (unchanged).

Reset
REQ-017 While rst_i=1 at an edge, the FSM SHALL go to IDLE, and wb_ack, wb_err and wb_dat_sm SHALL be 0.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 Reset asserted in RESP SHALL cancel the pending ack.
- A write captured before the reset stays committed.

Configuration
REQ-020 With macro WB_RAM_SLAVE_ERR_EN defined, an access outside [BASE_ADDR, BASE_ADDR+4*DEPTH) SHALL behave as follows:
- memory is not accessed and wb_dat_sm is unchanged;
- in RESP, wb_err is asserted instead of wb_ack, under the same wb_cyc & wb_stb gating.
REQ-021 Without WB_RAM_SLAVE_ERR_EN, wb_err SHALL be tied 0.
- Out-of-range addresses alias, per the truncation in REQ-014, and are acknowledged normally.

Structure
REQ-022 The Wishbone width constants (WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4) and the FSM state enum type SHALL live in shared package wb_pkg.
REQ-023 Storage SHALL be a sub-module wb_ram_slave_mem: single-port, byte-enabled, synchronous read/write, parameter DEPTH.
REQ-024 The FSM, address decode and ack/err generation SHALL stay in wb_ram_slave.

Verification
REQ-025 Reset: rst_i=1 for 2 cycles, then 0 -> wb_ack=0, wb_err=0, wb_dat_sm=0, FSM in IDLE.
REQ-026 Full write then read:
- write adr=BASE+0x10, sel=4'hF, data=32'hDEADBEEF -> ack exactly 1 cycle after capture;
- then read adr=BASE+0x10 -> ack, and wb_dat_sm=32'hDEADBEEF in the ack cycle.
REQ-027 Byte-lane write:
- preload 32'h11223344, then write sel=4'b0101, data=32'hAABBCCDD;
- read back -> 32'h11BB33DD.
REQ-028 Held strobe, 3 consecutive writes to adr 0x0, 0x4, 0x8 with stb held high -> acks on cycles 1, 3 and 5 after the first capture, and all three words written.
REQ-029 Abort: drop cyc in the RESP cycle of a write to 0x20 -> no ack; a later read of 0x20 returns the new data.
REQ-030 Out of range, DEPTH=1024 with BASE=0, read adr=0x1000:
- with WB_RAM_SLAVE_ERR_EN -> err=1 for 1 cycle, ack=0;
- without it -> ack=1, and data equals word 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone width constants and the slave FSM state type.
package wb_pkg;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  typedef enum logic {IDLE, RESP} wb_state_e;
endpackage

// File: rtl/wb_bus_t.sv
// wb_bus_t: Wishbone classic bus bundle with master and slave views.
interface wb_bus_t;
  import wb_pkg::*;
  logic                wb_cyc;
  logic                wb_stb;
  logic                wb_we;
  logic [WB_ADR_W-1:0] wb_adr;
  logic [WB_SEL_W-1:0] wb_sel;
  logic [WB_DAT_W-1:0] wb_dat_ms;
  logic [WB_DAT_W-1:0] wb_dat_sm;
  logic                wb_ack;
  logic                wb_err;
  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
    output wb_dat_sm, wb_ack, wb_err
  );
  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
    input  wb_dat_sm, wb_ack, wb_err
  );
endinterface

// File: rtl/wb_ram_slave_mem.sv
// wb_ram_slave_mem: single-port byte-enabled RAM with registered, held read data.
module wb_ram_slave_mem
  import wb_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [WB_SEL_W-1:0]      sel_i,
  input  logic [WB_DAT_W-1:0]      wdat_i,
  output logic [WB_DAT_W-1:0]      rdat_o
);
  logic [WB_DAT_W-1:0] mem_q [DEPTH];
  logic [WB_DAT_W-1:0] rdat_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_SEL_W; i++)
      if (en_i && we_i && sel_i[i]) mem_q[idx_i][8*i +: 8] <= wdat_i[8*i +: 8];
  end
  // only the read register is cleared; the array keeps its contents across reset
  always_ff @(posedge clk) begin
    if (rst_i) rdat_q <= '0;
    else if (en_i && !we_i) rdat_q <= mem_q[idx_i];
  end
  assign rdat_o = rdat_q;
endmodule

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone RAM slave, one ack per access at latency 1.
// Define WB_RAM_SLAVE_ERR_EN to answer out-of-window accesses with wb_err instead of aliasing.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int                  DEPTH     = 1024,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst_i,
  wb_bus_t.slave wb_bus
);
  localparam int AW = $clog2(DEPTH);
  wb_state_e           state_q, state_d;
  logic                err_q, err_d;
  logic                req, cap, hit;
  logic [WB_ADR_W-1:0] off;
  logic                unused_bits;
  assign req = wb_bus.wb_cyc & wb_bus.wb_stb;
  assign cap = (state_q == IDLE) & req & ~rst_i;
  assign off = wb_bus.wb_adr - BASE_ADDR;
`ifdef WB_RAM_SLAVE_ERR_EN
  assign hit         = off[WB_ADR_W-1:AW+2] == '0;
  assign unused_bits = ^off[1:0];
  assign wb_bus.wb_err = (state_q == RESP) & req & err_q & ~rst_i;
`else
  assign hit         = 1'b1;
  assign unused_bits = ^{off[WB_ADR_W-1:AW+2], off[1:0]};
  assign wb_bus.wb_err = 1'b0;
`endif
  always_comb begin
    state_d = cap ? RESP : IDLE;
    err_d   = cap ? ~hit : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end
  // ack follows the live strobe so a master that drops cyc/stb aborts cleanly
  assign wb_bus.wb_ack = (state_q == RESP) & req & ~err_q & ~rst_i;
  wb_ram_slave_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_i (rst_i),
    .en_i  (cap & hit),
    .we_i  (wb_bus.wb_we),
    .idx_i (off[AW+1:2]),
    .sel_i (wb_bus.wb_sel),
    .wdat_i(wb_bus.wb_dat_ms),
    .rdat_o(wb_bus.wb_dat_sm)
  );
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: directed and random Wishbone traffic against an array reference model.
module tb_wb_ram_slave;
  import wb_pkg::*;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef WB_RAM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          held = 1'b0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_dat = '0;
  always #5 clk = ~clk;
  wb_bus_t bus();
  wb_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_i (rst),
    .wb_bus(bus)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic bit model(bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
    logic [31:0] off = adr - BASE;
    int unsigned i = (off / 4) % DEPTH;
    if (ERR_EN && off >= 4 * DEPTH) return 1'b1;
    if (we) begin
      for (int n = 0; n < 4; n++)
        if (sel[n]) ref_mem[i][8*n +: 8] = dat[8*n +: 8];
    end else begin
      ref_dat = ref_mem[i];
    end
    return 1'b0;
  endfunction
  task automatic drive(bit cyc, bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
    bus.wb_cyc = cyc;
    bus.wb_stb = cyc;
    bus.wb_we = we;
    bus.wb_adr = adr;
    bus.wb_sel = sel;
    bus.wb_dat_ms = dat;
  endtask
  task automatic xfer(string tag, bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat, bit hold);
    bit exp_err;
    int lat = 0;
    int exp_lat = held ? 2 : 1;
    bit ack_seen = 1'b0;
    bit err_seen = 1'b0;
    exp_err = model(we, adr, sel, dat);
    drive(1'b1, we, adr, sel, dat);
    while (!ack_seen && !err_seen && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      check({tag, ".excl"}, {31'b0, bus.wb_ack & bus.wb_err}, 32'd0);
      ack_seen = bus.wb_ack;
      err_seen = bus.wb_err;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".ack"}, {31'b0, ack_seen}, {31'b0, !exp_err});
    check({tag, ".err"}, {31'b0, err_seen}, {31'b0, exp_err});
    check({tag, ".dat"}, bus.wb_dat_sm, ref_dat);
    held = hold;
    if (!hold) begin
      drive(1'b0, 1'b0, '0, '0, '0);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [31:0] a;
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.ack", {31'b0, bus.wb_ack}, 32'd0);
    check("rst.err", {31'b0, bus.wb_err}, 32'd0);
    check("rst.dat", bus.wb_dat_sm, 32'd0);
    check("rst.state", {31'b0, dut.state_q}, {31'b0, IDLE});
    for (int i = 0; i < DEPTH; i++)
      xfer("pre", 1'b1, BASE + 32'(4 * i), 4'hF, $urandom, i != DEPTH - 1);
    xfer("w26", 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    xfer("r26", 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    check("r26.const", bus.wb_dat_sm, 32'hDEADBEEF);
    xfer("w27a", 1'b1, BASE + 32'h14, 4'hF, 32'h11223344, 1'b0);
    xfer("w27b", 1'b1, BASE + 32'h14, 4'b0101, 32'hAABBCCDD, 1'b0);
    xfer("r27", 1'b0, BASE + 32'h14, 4'hF, 32'h0, 1'b0);
    check("r27.const", bus.wb_dat_sm, 32'h11BB33DD);
    xfer("w27z", 1'b1, BASE + 32'h14, 4'h0, 32'hFFFFFFFF, 1'b0);
    xfer("r27z", 1'b0, BASE + 32'h14, 4'hF, 32'h0, 1'b0);
    xfer("h28a", 1'b1, BASE + 32'h0, 4'hF, 32'hA0A0A0A0, 1'b1);
    xfer("h28b", 1'b1, BASE + 32'h4, 4'hF, 32'hB1B1B1B1, 1'b1);
    xfer("h28c", 1'b1, BASE + 32'h8, 4'hF, 32'hC2C2C2C2, 1'b0);
    for (int i = 0; i < 3; i++) xfer("r28", 1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, 1'b0);
    void'(model(1'b1, BASE + 32'h20, 4'hF, 32'h5EED0020));
    drive(1'b1, 1'b1, BASE + 32'h20, 4'hF, 32'h5EED0020);
    @(posedge clk);
    #1;
    bus.wb_cyc = 1'b0;
    #1;
    check("ab.ack0", {31'b0, bus.wb_ack}, 32'd0);
    @(posedge clk);
    #1;
    check("ab.ack1", {31'b0, bus.wb_ack}, 32'd0);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    xfer("r29", 1'b0, BASE + 32'h20, 4'hF, 32'h0, 1'b0);
    check("r29.const", bus.wb_dat_sm, 32'h5EED0020);
    xfer("r30", 1'b0, BASE + 32'h1000, 4'hF, 32'h0, 1'b0);
    xfer("w30", 1'b1, BASE + 32'h1000, 4'hF, 32'h0BAD0BAD, 1'b0);
    xfer("r30w0", 1'b0, BASE, 4'hF, 32'h0, 1'b0);
    void'(model(1'b1, BASE + 32'h40, 4'hF, 32'hCAFEF00D));
    drive(1'b1, 1'b1, BASE + 32'h40, 4'hF, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rr.ack", {31'b0, bus.wb_ack}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_dat = '0;
    check("rr.ack2", {31'b0, bus.wb_ack}, 32'd0);
    check("rr.dat", bus.wb_dat_sm, 32'd0);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    xfer("rr.rd", 1'b0, BASE + 32'h40, 4'hF, 32'h0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      xfer("rnd", 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
           k != 299 && $urandom_range(0, 1) == 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
